// File: rtl/mux_pkg.sv
// mux_pkg -- shared constants and helpers for the registered N:1 mux.
//   MUX_MAX_NCH      : largest supported channel count
//   MUX_DEF_WIDTH    : default data width per channel
//   MUX_DEF_NCH      : default channel count
//   mux_clog2(n)     : ceil(log2(n)), never less than 1 (select needs a bit)
//   occ_e            : output-side occupancy (EMPTY / ONE / FULL)
package mux_pkg;

  localparam int MUX_MAX_NCH   = 16;
  localparam int MUX_DEF_WIDTH = 32;
  localparam int MUX_DEF_NCH   = 4;

  function automatic int mux_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // FULL is only reachable when the skid slot is built.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/mux_reg_slot.sv
// mux_reg_slot -- one word of storage with load / hold / clear.
//   clk_i : clock
//   rst_i : synchronous active-high reset (clears to zero)
//   clr_i : synchronous clear (flush), same effect as reset
//   ld_i  : load d_i on the rising edge
//   d_i   : word to load
//   q_o   : stored word
module mux_reg_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) q_q <= '0;
    else if (ld_i)      q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg -- N:1 channel mux with a registered, valid/ready output.
// Each accepted word carries {err, sel, data}; an out-of-range select
// yields zero data with err set.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   d                 : NCH*WIDTH flattened channels, channel i at d[i*WIDTH +: WIDTH]
//   sel               : channel select, sampled on accept
//   in_valid/in_ready : upstream handshake
//   flush             : drop every held word
//   dout/out_sel/out_err/out_valid/out_ready : downstream word + handshake
//
// Build option: define MUX_SKID_EN to add a skid slot. in_ready then comes
// from a register (no out_ready->in_ready path); without it in_ready is
// combinational from out_ready and the block holds at most one word.
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = MUX_DEF_WIDTH,
  parameter  int NCH   = MUX_DEF_NCH,
  localparam int SELW  = mux_clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   dout,
  output logic [SELW-1:0]    out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int WW = WIDTH + SELW + 1;

  occ_e            state_q, state_d;
  logic [WIDTH-1:0] sel_data;
  logic            sel_err;
  logic [WW-1:0]   in_word, out_q, out_din;
  logic            ld_out, accept, xfer;

  // Channel selection; unmatched selects fall through to zero data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++)
      if (sel == SELW'(i)) sel_data = d[i*WIDTH +: WIDTH];
  end

  assign sel_err = ({1'b0, sel} >= (SELW+1)'(NCH));
  assign in_word = {sel_err, sel, sel_data};

  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

`ifdef MUX_SKID_EN
  logic          in_ready_q, ld_skid;
  logic [WW-1:0] skid_q;

  // rst/flush gate the registered ready so neither can let a word in.
  assign in_ready = in_ready_q & ~rst & ~flush;
  // Draining FULL refills the output from the skid slot.
  assign out_din  = (state_q == OCC_FULL) ? skid_q : in_word;

  mux_reg_slot #(.W(WW)) u_skid (
    .clk_i(clk), .rst_i(rst), .clr_i(flush), .ld_i(ld_skid),
    .d_i(in_word), .q_o(skid_q)
  );
`else
  assign in_ready = (~out_valid | out_ready) & ~rst & ~flush;
  assign out_din  = in_word;
`endif

  always_comb begin
    state_d = state_q;
    ld_out  = 1'b0;
`ifdef MUX_SKID_EN
    ld_skid = 1'b0;
`endif
    case (state_q)
      OCC_EMPTY: if (accept) begin ld_out = 1'b1; state_d = OCC_ONE; end
      OCC_ONE: begin
        if (accept && xfer) ld_out = 1'b1;
`ifdef MUX_SKID_EN
        else if (accept) begin ld_skid = 1'b1; state_d = OCC_FULL; end
`endif
        else if (xfer) state_d = OCC_EMPTY;
      end
      OCC_FULL: if (xfer) begin ld_out = 1'b1; state_d = OCC_ONE; end
      default: state_d = OCC_EMPTY;
    endcase
    // accept is already masked by flush through in_ready
    if (flush) state_d = OCC_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
`ifdef MUX_SKID_EN
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifdef MUX_SKID_EN
      in_ready_q <= (state_d != OCC_FULL);
`endif
    end
  end

  mux_reg_slot #(.W(WW)) u_out (
    .clk_i(clk), .rst_i(rst), .clr_i(flush), .ld_i(ld_out),
    .d_i(out_din), .q_o(out_q)
  );

  assign dout    = out_q[WIDTH-1:0];
  assign out_sel = out_q[WIDTH +: SELW];
  assign out_err = out_q[WW-1];

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg: directed scenarios plus a randomized run checked
// against a queue model of the words held inside the block.
module tb_mux_nx1_reg;

  localparam int N = 4;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, flush, out_ready, in_ready, out_err, out_valid;
  logic [1:0]   sel, out_sel;
  logic [127:0] d;
  logic [31:0]  dout;

  mux_nx1_reg #(.WIDTH(32), .NCH(4)) u_dut (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .dout(dout), .out_sel(out_sel),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Three-channel instance for the out-of-range select case.
  logic         rst3, iv3, rdy3, fl3, err3, ov3, ordy3;
  logic [1:0]   sel3, osel3;
  logic [23:0]  d3;
  logic [7:0]   dout3;

  mux_nx1_reg #(.WIDTH(8), .NCH(3)) u_dut3 (
    .clk(clk), .rst(rst3), .d(d3), .sel(sel3), .in_valid(iv3),
    .in_ready(rdy3), .flush(fl3), .dout(dout3), .out_sel(osel3),
    .out_err(err3), .out_valid(ov3), .out_ready(ordy3)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  s;
    logic        err;
  } word_t;

  word_t q[$];
  int errors = 0, checks = 0;

  logic        o_valid, o_rdy, o_err, e_valid, e_rdy;
  logic [31:0] o_dout;
  logic [1:0]  o_sel;
  word_t       e_word;

  // One clock: drive, sample mid-cycle, record model expectations, then
  // advance the model at the rising edge.
  task automatic cyc(input logic iv, input logic [1:0] s, input logic [127:0] dd,
                     input logic ordy, input logic fl, input logic rs);
    word_t w;
    @(negedge clk);
    in_valid = iv; sel = s; d = dd; out_ready = ordy; flush = fl; rst = rs;
    #1;
    o_valid = out_valid; o_rdy = in_ready; o_dout = dout; o_sel = out_sel; o_err = out_err;
    e_valid = (q.size() != 0);
    e_word  = e_valid ? q[0] : '0;
`ifdef MUX_SKID_EN
    e_rdy = (q.size() < 2) && !rs && !fl;
`else
    e_rdy = (q.size() == 0 || ordy) && !rs && !fl;
`endif
    @(posedge clk);
    if (rs || fl) q.delete();
    else begin
      if (e_valid && ordy) void'(q.pop_front());
      if (iv && e_rdy) begin
        w.err  = (int'(s) >= N);
        w.s    = s;
        w.data = w.err ? 32'h0 : dd[32*int'(s) +: 32];
        q.push_back(w);
      end
    end
  endtask

  task automatic test_reset();
    cyc(0, 0, '0, 1, 0, 1);
    checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", o_rdy); end
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", o_dout); end
    checks++; if (o_sel !== 2'd0 || o_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got=%0d/%b exp=0/0", o_sel, o_err); end
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_after got=%b exp=1", o_rdy); end
  endtask

  task automatic test_basic();
    logic [127:0] dd;
    dd = '0; dd[95:64] = 32'hDEADBEEF;
    cyc(1, 2, dd, 1, 0, 0);
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy got=%b exp=1", o_rdy); end
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_word got=%b/%h exp=1/deadbeef", o_valid, o_dout); end
    checks++; if (o_sel !== 2'd2 || o_err !== 1'b0) begin errors++; $display("FAIL basic_sel got=%0d/%b exp=2/0", o_sel, o_err); end
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    iv3 = 1; sel3 = 2'd3; d3 = 24'hAABBCC; ordy3 = 1;
    @(negedge clk);
    sel3 = 2'd1;  // second word, in range
    #1;
    checks++; if (ov3 !== 1'b1 || dout3 !== 8'h00) begin errors++; $display("FAIL oor_data got=%b/%h exp=1/00", ov3, dout3); end
    checks++; if (err3 !== 1'b1 || osel3 !== 2'd3) begin errors++; $display("FAIL oor_err got=%b/%0d exp=1/3", err3, osel3); end
    @(negedge clk);
    iv3 = 0;
    #1;
    checks++; if (dout3 !== 8'hBB || err3 !== 1'b0 || osel3 !== 2'd1) begin errors++; $display("FAIL oor_inrange got=%h/%b/%0d exp=bb/0/1", dout3, err3, osel3); end
  endtask

  task automatic test_stall();
`ifdef MUX_SKID_EN
    cyc(1, 0, 128'h11, 0, 0, 0);
    cyc(1, 0, 128'h22, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0);
    checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL skid_full_rdy got=%b exp=0", o_rdy); end
    checks++; if (o_dout !== 32'h11) begin errors++; $display("FAIL skid_hold got=%h exp=11", o_dout); end
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dout !== 32'h11) begin errors++; $display("FAIL skid_a got=%b/%h exp=1/11", o_valid, o_dout); end
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dout !== 32'h22) begin errors++; $display("FAIL skid_b got=%b/%h exp=1/22", o_valid, o_dout); end
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL skid_rdy_again got=%b exp=1", o_rdy); end
`else
    cyc(1, 0, 128'h11, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy got=%b/%b exp=1/0", o_valid, o_rdy); end
    cyc(1, 0, 128'h22, 1, 0, 0);
    checks++; if (o_rdy !== 1'b1 || o_dout !== 32'h11) begin errors++; $display("FAIL b2b_a got=%b/%h exp=1/11", o_rdy, o_dout); end
    cyc(1, 0, 128'h33, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dout !== 32'h22) begin errors++; $display("FAIL b2b_b got=%b/%h exp=1/22", o_valid, o_dout); end
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dout !== 32'h33) begin errors++; $display("FAIL b2b_c got=%b/%h exp=1/33", o_valid, o_dout); end
`endif
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_flush();
    cyc(1, 0, 128'h11, 0, 0, 0);
`ifdef MUX_SKID_EN
    cyc(1, 0, 128'h22, 0, 0, 0);
`endif
    cyc(1, 0, 128'h33, 0, 1, 0);
    checks++; if (o_rdy !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL flush_cycle got=%b/%b exp=0/1", o_rdy, o_valid); end
    cyc(1, 0, 128'h44, 0, 0, 0);
    checks++; if (o_valid !== 1'b0 || o_rdy !== 1'b1) begin errors++; $display("FAIL flush_after got=%b/%b exp=0/1", o_valid, o_rdy); end
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dout !== 32'h44) begin errors++; $display("FAIL flush_next got=%b/%h exp=1/44", o_valid, o_dout); end
    cyc(0, 0, '0, 1, 0, 0);
  endtask

  task automatic test_rst_stall();
    logic [127:0] dd;
    dd = '0; dd[63:32] = 32'h5555AAAA;
    cyc(1, 1, dd, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_sel !== 2'd1) begin errors++; $display("FAIL rst_pre got=%b/%0d exp=1/1", o_valid, o_sel); end
    cyc(1, 0, '0, 0, 0, 1);
    checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got=%b exp=0", o_rdy); end
    cyc(0, 0, '0, 0, 0, 0);
    checks++; if (o_valid !== 1'b0 || o_dout !== 32'h0 || o_sel !== 2'd0 || o_err !== 1'b0) begin errors++; $display("FAIL rst_clear got=%b/%h/%0d/%b exp=0/0/0/0", o_valid, o_dout, o_sel, o_err); end
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy_after got=%b exp=1", o_rdy); end
    dd = '0; dd[127:96] = 32'hCAFEF00D;
    cyc(1, 3, dd, 1, 0, 0);
    cyc(0, 0, '0, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dout !== 32'hCAFEF00D || o_sel !== 2'd3) begin errors++; $display("FAIL rst_first got=%b/%h/%0d exp=1/cafef00d/3", o_valid, o_dout, o_sel); end
  endtask

  task automatic test_random();
    logic [127:0] dd;
    for (int n = 0; n < 400; n++) begin
      dd = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom % 4) != 0, 2'($urandom), dd, ($urandom % 3) != 0,
          ($urandom % 40) == 0, ($urandom % 60) == 0);
      checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, o_valid, e_valid); end
      checks++; if (o_rdy !== e_rdy) begin errors++; $display("FAIL rnd_rdy n=%0d got=%b exp=%b", n, o_rdy, e_rdy); end
      if (e_valid) begin
        checks++;
        if (o_dout !== e_word.data || o_sel !== e_word.s || o_err !== e_word.err) begin
          errors++;
          $display("FAIL rnd_word n=%0d got=%h/%0d/%b exp=%h/%0d/%b", n, o_dout, o_sel, o_err,
                   e_word.data, e_word.s, e_word.err);
        end
      end
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; sel = 0; d = '0;
    rst3 = 1; iv3 = 0; fl3 = 0; ordy3 = 0; sel3 = 0; d3 = '0;
    test_reset();
    rst3 = 0;
    test_basic();
    test_out_of_range();
    test_stall();
    test_flush();
    test_rst_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_nx1_reg.md
MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (>=1).
REQ-002 Parameter NCH, default 4, number of input channels (2..16).
REQ-003 Localparam SELW = clog2(NCH), minimum 1.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 d  in  NCH*WIDTH  flattened channels; channel i = d[i*WIDTH +: WIDTH].
REQ-007 sel  in  SELW  channel select, sampled on accept.
REQ-008 in_valid  in  1  upstream word available.
REQ-009 in_ready  out  1  block can accept this cycle.
REQ-010 flush  in  1  discard all held words.
REQ-011 dout  out  WIDTH  selected, registered data.
REQ-012 out_sel  out  SELW  sel value that produced dout.
REQ-013 out_err  out  1  dout came from out-of-range sel (sel >= NCH).
REQ-014 out_valid  out  1  dout/out_sel/out_err valid.
REQ-015 out_ready  in  1  downstream consumes when out_valid=1.

Function
REQ-016 Accept = in_valid & in_ready; capture d[sel], sel and (sel>=NCH) as one word.
REQ-017 Out-of-range sel: captured data SHALL be all zeros, out_err=1 with that word.
REQ-018 Latency: word accepted at edge k appears with out_valid=1 after edge k (one cycle).
REQ-019 Output transfer = out_valid & out_ready; otherwise dout, out_sel, out_err held stable.
REQ-020 Words leave in acceptance order; none dropped or duplicated except by flush/rst.
REQ-021 Accept and output transfer in the same cycle SHALL both occur; output takes new word.
REQ-022 flush: after the edge, out_valid=0 and skid empty; in_ready=0 in the flush cycle; flush overrides simultaneous accept.
REQ-023 in_ready SHALL be 0 while rst=1.
REQ-024 Occupancy states: EMPTY (out_valid=0), ONE (out only), FULL (out + skid, skid build only).
REQ-025 EMPTY->ONE on accept; ONE->EMPTY on transfer without accept; ONE->FULL on accept while output stalled; FULL->ONE on transfer (skid word moves to output); any->EMPTY on flush.

Reset
REQ-026 On rst: out_valid=0, dout=0, out_sel=0, out_err=0, skid empty, state EMPTY.
REQ-027 rst asserted mid-stall SHALL discard output and skid words; first accept after rst deassert behaves as from EMPTY.

Configuration
REQ-028 Macro MUX_SKID_EN selects the skid buffer.
REQ-029 With MUX_SKID_EN: in_ready registered, = (state != FULL) & !rst & !flush; no combinational path out_ready->in_ready.
REQ-030 Without MUX_SKID_EN: no skid register, state FULL unreachable; in_ready = (!out_valid | out_ready) & !rst & !flush (combinational).
REQ-031 Both builds SHALL give identical word sequences at the output for the same accepted inputs.

Structure
REQ-032 Shared package/header mux_pkg holds clog2 helper, MUX_MAX_NCH=16 and default WIDTH/NCH constants.
REQ-033 One sub-module mux_reg_slot (WIDTH+SELW+1-bit load/hold/clear register) SHALL be used for the output slot and the skid slot.
REQ-034 Channel selection logic SHALL be combinational inside mux_nx1_reg; no other sub-modules.

Verification
REQ-035 WIDTH=32,NCH=4, out_ready=1, sel=2, d[2]=0xDEADBEEF, in_valid one cycle -> next cycle dout=0xDEADBEEF, out_sel=2, out_valid=1, out_err=0.
REQ-036 NCH=3, sel=3 accepted -> dout=0, out_err=1, out_sel=3.
REQ-037 MUX_SKID_EN, out_ready=0, accept words A=0x11 then B=0x22 -> in_ready=0 after B; raise out_ready -> A then B on consecutive cycles, in_ready=1 again.
REQ-038 Without macro, out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> back-to-back words, one per cycle.
REQ-039 FULL state, assert flush one cycle with in_valid=1 -> out_valid=0 next cycle, no word accepted, following accept reaches output after one cycle.
REQ-040 rst pulse during stall with out_valid=1 -> all outputs zero next cycle, in_ready=0 during rst, 1 after.
